arb_fifo: RTL and testbench

- Synchronous FIFO directly downstream of the multi-writer arbiter.
- Accepts the arbiter's write strobe and 8-bit data bus, and buffers the words in arrival order.
- Presents the words to a single consumer through a registered read port.
- Drives full and almost-full back toward the arbiter so it can hold writers busy.

---
 rtl/arb_fifo_if.sv | 30 +++
 rtl/arb_fifo.sv | 95 +++++++++
 tb/tb_arb_fifo.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/arb_fifo_if.sv
// Handshake bundle between the write arbiter / read consumer and arb_fifo.
// master: arbiter plus consumer side; slave: the FIFO itself.
interface arb_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic                  i_we;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_full;
  logic                  o_almost_full;
  logic                  i_re;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_rvalid;
  logic                  o_empty;
  logic [CountW-1:0]     o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_we, i_data, i_re,
    input  o_full, o_almost_full, o_data, o_rvalid, o_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_we, i_data, i_re,
    output o_full, o_almost_full, o_data, o_rvalid, o_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/arb_fifo.sv
// Synchronous FIFO behind the multi-writer arbiter, with registered read port and sticky
// overflow/underflow flags. Define ARB_FIFO_ALMOST_FULL_EN to drive o_almost_full.
module arb_fifo #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
  input logic       i_clk,
  input logic       i_reset_n,
  arb_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_param
    $error("arb_fifo: illegal DEPTH / ALMOST_FULL_LEVEL");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty, rd_ok, wr_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign rd_ok = bus.i_re && !empty;
  // A read on the same edge frees the slot, so a full FIFO still takes the write.
  assign wr_ok = bus.i_we && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = rd_ok;
    ovf_d    = ovf_q || (bus.i_we && !wr_ok);
    udf_d    = udf_q || (bus.i_re && !rd_ok);
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_q[rd_ptr_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.i_data;
  end

  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_count     = count_q;
  assign bus.o_data      = rdata_q;
  assign bus.o_rvalid    = rvalid_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;

`ifdef ARB_FIFO_ALMOST_FULL_EN
  assign bus.o_almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));
`else
  assign bus.o_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_arb_fifo.sv
// Directed bench for arb_fifo: a reference queue predicts every read word and all flags.
module tb_arb_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFL   = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  arb_fifo #(
    .DATA_WIDTH       (DW),
    .DEPTH            (DEPTH),
    .ALMOST_FULL_LEVEL(AFL)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] fifo_m [$];
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] last_m;
  logic          ovf_m, udf_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_af();
`ifdef ARB_FIFO_ALMOST_FULL_EN
    return fifo_m.size() >= AFL;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_flags();
    check("count", 32'(bus.o_count), fifo_m.size());
    check("empty", 32'(bus.o_empty), 32'(fifo_m.size() == 0));
    check("full", 32'(bus.o_full), 32'(fifo_m.size() == DEPTH));
    check("almost_full", 32'(bus.o_almost_full), 32'(exp_af()));
    check("overflow", 32'(bus.o_overflow), 32'(ovf_m));
    check("underflow", 32'(bus.o_underflow), 32'(udf_m));
  endtask

  // One clock: drive inputs, update the model, then check outputs 1 time unit after the edge.
  task automatic cycle(input logic we, input logic [DW-1:0] d, input logic re);
    logic rd_ok, wr_ok;
    bus.i_we   = we;
    bus.i_data = d;
    bus.i_re   = re;
    rd_ok = re && (fifo_m.size() != 0);
    wr_ok = we && ((fifo_m.size() < DEPTH) || rd_ok);
    if (rd_ok) exp_q.push_back(fifo_m.pop_front());
    if (wr_ok) fifo_m.push_back(d);
    if (we && !wr_ok) ovf_m = 1'b1;
    if (re && !rd_ok) udf_m = 1'b1;
    @(posedge clk);
    #1;
    bus.i_we = 1'b0;
    bus.i_re = 1'b0;
    check("rvalid", 32'(bus.o_rvalid), 32'(rd_ok));
    if (bus.o_rvalid) begin
      if (exp_q.size() == 0) check("spurious_rvalid", 32'(bus.o_rvalid), 32'd0);
      else last_m = exp_q.pop_front();
    end
    check("rdata", 32'(bus.o_data), 32'(last_m));
    check_flags();
  endtask

  task automatic model_reset();
    fifo_m.delete();
    exp_q.delete();
    last_m = '0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
  endtask

  // Assert reset between clock edges and check that it takes effect without a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
    check("rst_rdata", 32'(bus.o_data), 32'd0);
    check_flags();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.i_we   = 1'b0;
    bus.i_re   = 1'b0;
    bus.i_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    repeat (5) cycle(1'b0, 8'h00, 1'b0);

    // Three writes then three reads
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Fill, overflow with 0xAA, drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    check("ovf_set", 32'(bus.o_overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Simultaneous write+read at full; 0x55 must come out last
    async_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    check("full_wr_rd_count", 32'(bus.o_count), DEPTH);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    check("last_drained", 32'(bus.o_data), 32'h55);
    cycle(1'b0, 8'h00, 1'b0);

    // Underflow, then write+read while empty
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h77, 1'b1);
    check("empty_wr_rd_count", 32'(bus.o_count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("read_77", 32'(bus.o_data), 32'h77);
    cycle(1'b0, 8'h00, 1'b0);

    // Almost-full threshold crossing up and down
    async_reset();
    for (int i = 0; i < AFL; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hD0, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // Mid-operation reset with 8 entries
    async_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0);
    async_reset();
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    check("sb_leftover", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
